// File: rtl/l2_mem_wbuf.sv
// Write buffer and memory-port arbiter between the L2 memory-side port and main memory.
// Buffered lines serve read hits, absorb write-backs and drain to memory when the L2 is idle.
module l2_mem_wbuf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic                     clk,
  input  logic                     proc_reset_n,
  input  logic                     cache_read,
  input  logic                     cache_write,
  input  logic [ADDR_W-1:0]        cache_addr,
  input  logic [DATA_W-1:0]        cache_wdata,
  output logic [DATA_W-1:0]        cache_rdata,
  output logic                     cache_ready,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ready,
  output logic [$clog2(DEPTH):0]   wbuf_count,
  output logic                     wbuf_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Handshakes: L2 holds cache_read/cache_write with stable address/data until the
  // one-cycle cache_ready pulse; memory holds mem_read/mem_write until the one-cycle mem_ready.
  typedef enum logic [1:0] {IDLE, RESP, MRD, MWR} state_t;

  state_t state;
  state_t state_next;

  logic [DEPTH-1:0]  valid;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              hit;
  logic [PTR_W-1:0]  hit_idx;
  logic              full;

  logic rd_hit;
  logic rd_miss;
  logic wr_merge;
  logic wr_push;
  logic drain_start;
  logic drain_done;
  logic fill_done;

  assign full       = (count == FULL_CNT);
  assign wbuf_empty = (count == '0);
  assign wbuf_count = count;

  // Writes coalesce, so at most one valid entry can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (addr_mem[i] == cache_addr)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    rd_hit      = 1'b0;
    rd_miss     = 1'b0;
    wr_merge    = 1'b0;
    wr_push     = 1'b0;
    drain_start = 1'b0;
    drain_done  = 1'b0;
    fill_done   = 1'b0;
    cache_ready = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    case (state)
      IDLE: begin
        if (cache_read) begin
          if (hit) begin
            rd_hit     = 1'b1;
            state_next = RESP;
          end else begin
            rd_miss    = 1'b1;
            state_next = MRD;
          end
        end else if (cache_write) begin
          if (hit) begin
            wr_merge   = 1'b1;
            state_next = RESP;
          end else if (!full) begin
            wr_push    = 1'b1;
            state_next = RESP;
          end else begin
            // Make room first; the held write is retried on the next IDLE visit.
            drain_start = 1'b1;
            state_next  = MWR;
          end
        end else if (!wbuf_empty) begin
          drain_start = 1'b1;
          state_next  = MWR;
        end
      end
      RESP: begin
        cache_ready = 1'b1;
        state_next  = IDLE;
      end
      MRD: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          fill_done  = 1'b1;
          state_next = RESP;
        end
      end
      MWR: begin
        mem_write = 1'b1;
        if (mem_ready) begin
          drain_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      valid       <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      cache_rdata <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      if (rd_hit) begin
        cache_rdata <= data_mem[hit_idx];
      end
      if (fill_done) begin
        cache_rdata <= mem_rdata;
      end
      if (rd_miss) begin
        mem_addr <= cache_addr;
      end
      if (drain_start) begin
        mem_addr  <= addr_mem[head];
        mem_wdata <= data_mem[head];
      end
      if (wr_push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
        count       <= count + 1'b1;
      end
      if (drain_done) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
        count       <= count - 1'b1;
      end
    end
  end

  // Line storage needs no reset: the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (wr_push) begin
      addr_mem[tail] <= cache_addr;
      data_mem[tail] <= cache_wdata;
    end
    if (wr_merge) begin
      data_mem[hit_idx] <= cache_wdata;
    end
  end

  assert property (@(posedge clk) disable iff (!proc_reset_n) !(mem_read && mem_write));
  assert property (@(posedge clk) disable iff (!proc_reset_n) count <= FULL_CNT);

endmodule

// File: tb/tb_l2_mem_wbuf.sv
// Bench for l2_mem_wbuf: directed vector table, hand-written corner sequences and a
// random phase checked against a coherent-memory model plus a FIFO drain scoreboard.
module tb_l2_mem_wbuf;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              proc_reset_n;
  logic              cache_read;
  logic              cache_write;
  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_wdata;
  logic [DATA_W-1:0] cache_rdata;
  logic              cache_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [CNT_W-1:0]  wbuf_count;
  logic              wbuf_empty;

  l2_mem_wbuf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .cache_read(cache_read), .cache_write(cache_write),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_rdata(cache_rdata), .cache_ready(cache_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wbuf_count(wbuf_count), .wbuf_empty(wbuf_empty)
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // Reference model: shadow = last line written by the L2 per address (what any read must
  // return); exp_q/pend = buffered lines in first-insertion order with their latest data.
  logic [ADDR_W-1:0] exp_q[$];
  logic [DATA_W-1:0] pend[logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] shadow[logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] mem_arr[logic [ADDR_W-1:0]];

  // memory responder controls
  bit mem_hold;
  bit rand_lat;
  int fixed_lat;
  int wait_cnt;
  int lat_target;
  int pulse_req;
  int pulse_ack;
  bit saw_mem_read;

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return {4{16'hBEEF, a[15:0]}};
  endfunction

  function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_val(a);
  endfunction

  function automatic logic [DATA_W-1:0] arch_val(input logic [ADDR_W-1:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  task automatic chk_val(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  // Drive one mem_ready pulse; a completing write is scored against the drain order.
  task automatic fire();
    logic [ADDR_W-1:0] a;
    mem_ready = 1'b1;
    if (mem_read) mem_rdata = mem_val(mem_addr);
    else mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (mem_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_unexpected addr=%0h required=no_drain", mem_addr);
      end else begin
        a = exp_q.pop_front();
        chk_val("drain_addr", DATA_W'(mem_addr), DATA_W'(a));
        chk_val("drain_data", mem_wdata, pend[a]);
        pend.delete(a);
      end
      mem_arr[mem_addr] = mem_wdata;
    end
  endtask

  task automatic mem_tick();
    if (mem_read || mem_write) chk_bit("mem_rw_excl", mem_read & mem_write, 1'b0);
    if (mem_read) saw_mem_read = 1'b1;
    if (mem_ready) begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end else if (pulse_req != pulse_ack) begin
      pulse_ack++;
      fire();
    end else if (!mem_hold && (mem_read || mem_write)) begin
      if (wait_cnt >= lat_target) begin
        fire();
        wait_cnt   = 0;
        lat_target = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
      end else begin
        wait_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mem_tick();
  endtask

  task automatic drop();
    cache_read  = 1'b0;
    cache_write = 1'b0;
  endtask

  // Present a request and wait (bounded) for cache_ready; the request stays asserted.
  task automatic do_request(input bit is_wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            output int lat, output logic [DATA_W-1:0] rdata);
    bit ok;
    cache_addr   = a;
    cache_wdata  = d;
    cache_read   = !is_wr;
    cache_write  = is_wr;
    saw_mem_read = 1'b0;
    lat   = 0;
    ok    = 1'b0;
    rdata = '0;
    while (lat < 200 && !ok) begin
      tick();
      lat++;
      if (cache_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_timeout addr=%0h actual=no_ready required=ready", a);
    end else begin
      rdata = cache_rdata;
      if (is_wr) begin
        shadow[a] = d;
        if (!pend.exists(a)) exp_q.push_back(a);
        pend[a] = d;
        chk_val("wr_count", DATA_W'(wbuf_count), DATA_W'(exp_q.size()));
      end else begin
        chk_val("read_data", cache_rdata, arch_val(a));
      end
    end
  endtask

  task automatic drain_all();
    int n;
    drop();
    mem_hold = 1'b0;
    rand_lat = 1'b1;
    n = 0;
    while (n < 400 && !(wbuf_empty && !mem_write && !mem_ready)) begin
      tick();
      n++;
    end
    chk_bit("drain_empty", wbuf_empty, 1'b1);
    chk_val("drain_model_empty", DATA_W'(exp_q.size()), '0);
  endtask

  typedef struct {
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp_rdata;
    int                exp_count;
    bit                exp_mem;
  } vec_t;

  vec_t vecs[10];

  localparam logic [DATA_W-1:0] D1 = {32{4'h1}};
  localparam logic [DATA_W-1:0] D2 = {32{4'h2}};
  localparam logic [DATA_W-1:0] D3 = {32{4'h3}};
  localparam logic [DATA_W-1:0] D4 = {32{4'h4}};
  localparam logic [DATA_W-1:0] D5 = {32{4'h5}};
  localparam logic [DATA_W-1:0] D6 = {32{4'h6}};
  localparam logic [DATA_W-1:0] D7 = {32{4'h7}};
  localparam logic [DATA_W-1:0] DA = {32{4'hA}};

  int                lat;
  int                n;
  int                r;
  bit                quiet;
  logic [DATA_W-1:0] rd;
  logic [ADDR_W-1:0] a;

  initial begin
    vecs[0] = '{1'b1, 28'h30, D3, '0, 1, 1'b0};
    vecs[1] = '{1'b0, 28'h30, '0, D3, 1, 1'b0};
    vecs[2] = '{1'b1, 28'h40, D4, '0, 2, 1'b0};
    vecs[3] = '{1'b1, 28'h30, D5, '0, 2, 1'b0};
    vecs[4] = '{1'b0, 28'h30, '0, D5, 2, 1'b0};
    vecs[5] = '{1'b0, 28'h31, '0, 128'hBEEF0031_BEEF0031_BEEF0031_BEEF0031, 2, 1'b1};
    vecs[6] = '{1'b1, 28'h50, D6, '0, 3, 1'b0};
    vecs[7] = '{1'b1, 28'h60, D7, '0, 4, 1'b0};
    vecs[8] = '{1'b0, 28'h60, '0, D7, 4, 1'b0};
    vecs[9] = '{1'b0, 28'h40, '0, D4, 4, 1'b0};

    proc_reset_n = 1'b0;
    cache_read   = 1'b0;
    cache_write  = 1'b0;
    cache_addr   = '0;
    cache_wdata  = '0;
    mem_rdata    = '0;
    mem_ready    = 1'b0;
    mem_hold     = 1'b1;
    rand_lat     = 1'b0;
    fixed_lat    = 2;
    wait_cnt     = 0;
    lat_target   = 2;
    pulse_req    = 0;
    pulse_ack    = 0;
    saw_mem_read = 1'b0;

    // reset hold, release, quiet idle
    repeat (3) tick();
    proc_reset_n = 1'b1;
    tick();
    chk_bit("rst_cache_ready", cache_ready, 1'b0);
    chk_bit("rst_mem_read", mem_read, 1'b0);
    chk_bit("rst_mem_write", mem_write, 1'b0);
    chk_val("rst_cache_rdata", cache_rdata, '0);
    chk_val("rst_mem_addr", DATA_W'(mem_addr), '0);
    chk_val("rst_mem_wdata", mem_wdata, '0);
    chk_bit("rst_wbuf_empty", wbuf_empty, 1'b1);
    chk_val("rst_wbuf_count", DATA_W'(wbuf_count), '0);
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_read || mem_write) quiet = 1'b0;
    end
    chk_bit("rst_idle_quiet", quiet, 1'b1);

    // single write, one-cycle accept, drain with memory answering after 5 cycles
    do_request(1'b1, 28'h10, DA, lat, rd);
    chk_val("b_write_latency", DATA_W'(lat), DATA_W'(1));
    chk_val("b_count", DATA_W'(wbuf_count), DATA_W'(1));
    drop();
    tick();
    chk_bit("b_no_early_drain", mem_write, 1'b0);
    tick();
    chk_bit("b_drain_write", mem_write, 1'b1);
    chk_val("b_drain_addr", DATA_W'(mem_addr), DATA_W'(28'h10));
    chk_val("b_drain_data", mem_wdata, DA);
    quiet = 1'b1;
    repeat (4) begin
      tick();
      if (!mem_write) quiet = 1'b0;
    end
    chk_bit("b_write_held", quiet, 1'b1);
    pulse_req++;
    tick();
    tick();
    chk_bit("b_empty_after", wbuf_empty, 1'b1);
    chk_bit("b_write_dropped", mem_write, 1'b0);

    // vector table: back-to-back requests, no idle gap so nothing drains
    mem_hold  = 1'b0;
    rand_lat  = 1'b0;
    fixed_lat = 2;
    lat_target = 2;
    for (int i = 0; i < 10; i++) begin
      do_request(vecs[i].wr, vecs[i].addr, vecs[i].data, lat, rd);
      chk_val($sformatf("vec%0d_count", i), DATA_W'(wbuf_count), DATA_W'(vecs[i].exp_count));
      chk_bit($sformatf("vec%0d_mem_read", i), saw_mem_read, vecs[i].exp_mem);
      if (!vecs[i].wr) chk_val($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end
    drain_all();

    // full buffer: fifth write waits for the head drain, then lands in the wrapped slot
    mem_hold = 1'b1;
    for (int i = 1; i <= 4; i++) do_request(1'b1, ADDR_W'(i), {4{$urandom}}, lat, rd);
    cache_addr  = 28'h5;
    cache_wdata = D5;
    cache_write = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      tick();
      if (cache_ready) quiet = 1'b0;
    end
    chk_bit("c_ready_held_off", quiet, 1'b1);
    chk_bit("c_drain_started", mem_write, 1'b1);
    chk_val("c_drain_head", DATA_W'(mem_addr), DATA_W'(28'h1));
    chk_val("c_count_full", DATA_W'(wbuf_count), DATA_W'(4));
    pulse_req++;
    do_request(1'b1, 28'h5, D5, lat, rd);
    chk_val("c_count_after", DATA_W'(wbuf_count), DATA_W'(4));
    drain_all();

    // coalesce: second write to the same line replaces the data, count unchanged
    mem_hold = 1'b1;
    do_request(1'b1, 28'h20, D1, lat, rd);
    do_request(1'b1, 28'h20, D2, lat, rd);
    chk_val("d_count", DATA_W'(wbuf_count), DATA_W'(1));
    drop();
    n = 0;
    while (!mem_write && n < 20) begin
      tick();
      n++;
    end
    chk_bit("d_drain_start", mem_write, 1'b1);
    chk_val("d_drain_data", mem_wdata, D2);
    pulse_req++;
    drain_all();

    // read miss: memory data returned one cycle after mem_ready
    mem_hold    = 1'b1;
    cache_addr  = 28'h32;
    cache_read  = 1'b1;
    tick();
    chk_bit("e_mem_read", mem_read, 1'b1);
    chk_val("e_mem_addr", DATA_W'(mem_addr), DATA_W'(28'h32));
    repeat (3) tick();
    chk_bit("e_read_held", mem_read, 1'b1);
    pulse_req++;
    tick();
    chk_bit("e_no_early_ready", cache_ready, 1'b0);
    tick();
    chk_bit("e_ready", cache_ready, 1'b1);
    chk_val("e_rdata", cache_rdata, 128'hBEEF0032_BEEF0032_BEEF0032_BEEF0032);
    chk_bit("e_read_dropped", mem_read, 1'b0);
    drop();
    tick();

    // reset during a drain with three lines buffered
    do_request(1'b1, 28'h70, D1, lat, rd);
    do_request(1'b1, 28'h71, D2, lat, rd);
    do_request(1'b1, 28'h72, D3, lat, rd);
    drop();
    n = 0;
    while (!mem_write && n < 20) begin
      tick();
      n++;
    end
    chk_bit("f_drain_start", mem_write, 1'b1);
    proc_reset_n = 1'b0;
    tick();
    chk_bit("f_write_aborted", mem_write, 1'b0);
    chk_val("f_count_cleared", DATA_W'(wbuf_count), '0);
    chk_bit("f_empty", wbuf_empty, 1'b1);
    chk_val("f_mem_addr", DATA_W'(mem_addr), '0);
    proc_reset_n = 1'b1;
    foreach (pend[k]) shadow[k] = mem_val(k);
    pend.delete();
    exp_q.delete();
    pulse_req++;
    quiet = 1'b1;
    repeat (10) begin
      tick();
      if (mem_read || mem_write) quiet = 1'b0;
    end
    chk_bit("f_quiet_after_late_ready", quiet, 1'b1);

    // random traffic over a small address window against the model
    mem_hold = 1'b0;
    rand_lat = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      a = ADDR_W'(32'h100 + $urandom_range(0, 7));
      if (r < 40) begin
        do_request(1'b0, a, '0, lat, rd);
      end else if (r < 85) begin
        do_request(1'b1, a, {$urandom, $urandom, $urandom, $urandom}, lat, rd);
      end else begin
        drop();
        repeat ($urandom_range(1, 6)) tick();
      end
    end
    drain_all();
    for (int i = 0; i < 8; i++) begin
      a = ADDR_W'(32'h100 + i);
      do_request(1'b0, a, '0, lat, rd);
    end
    drop();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_mem_wbuf.md
Name: l2_mem_wbuf

Overview:
- Write buffer and memory-port arbiter between the L2 cache's memory-side port and main memory.
- Absorbs L2 line write-backs so the L2 is not held for the full memory write latency.
- Serves L2 line reads from buffered data on an address match, otherwise forwards them to memory.
- Drains buffered lines to memory whenever the L2 port is idle.

Parameters:
- DEPTH, 4, buffer entries (power of 2, ≥2)
- ADDR_W, 28, line address width
- DATA_W, 128, line data width (4 words)

Ports:
- clk  in  1  clock
- proc_reset_n  in  1  synchronous active-low reset
- cache_read  in  1  L2 line read request; held with stable address until cache_ready
- cache_write  in  1  L2 line write request; held with stable address/data until cache_ready
- cache_addr  in  ADDR_W  line address from L2
- cache_wdata  in  DATA_W  write-back line from L2
- cache_rdata  out  DATA_W  line returned to L2; registered, valid while cache_ready=1
- cache_ready  out  1  one-cycle completion pulse to L2
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_addr  out  ADDR_W  memory line address
- mem_wdata  out  DATA_W  memory write line
- mem_rdata  in  DATA_W  memory read line
- mem_ready  in  1  one-cycle memory completion pulse
- wbuf_count  out  log2(DEPTH)+1  occupied entries
- wbuf_empty  out  1  wbuf_count==0

Behaviour:
- Reset (proc_reset_n=0 at a clk edge):
  - state=IDLE; all entries invalid; head=tail=0.
  - cache_ready, mem_read, mem_write = 0; cache_rdata, mem_addr, mem_wdata = 0.
  - Reset mid-transaction discards buffered lines and aborts the memory access; mem_read/mem_write are low from the next cycle.
- Storage: circular FIFO of {addr, data}. At most one valid entry per address (writes coalesce).
- Address match: compare cache_addr against all valid entries, combinationally.
- FSM states: IDLE, RESP, MRD, MWR.
- IDLE, evaluated in priority order:
  1. cache_read with a match: latch entry data into cache_rdata; go RESP.
  2. cache_read without a match: latch mem_addr=cache_addr; go MRD.
  3. cache_write with a match: overwrite that entry's data; go RESP.
  4. cache_write, no match, not full: enqueue at tail; go RESP.
  5. cache_write, no match, full: go MWR. The head drains first; the write is accepted on a later IDLE visit.
  6. No request and not empty: go MWR.
  7. Otherwise stay in IDLE.
- Simultaneous cache_read and cache_write: read wins; write is ignored that cycle.
- RESP: cache_ready=1 for exactly one cycle, then IDLE. The requester must drop its request in the following cycle.
- MRD:
  - mem_read=1; mem_addr held.
  - On mem_ready: cache_rdata<=mem_rdata, mem_read drops next cycle, go RESP.
- MWR:
  - mem_write=1; mem_addr/mem_wdata = head entry, registered on entry to MWR and held.
  - On mem_ready: invalidate head, head++ (wraps mod DEPTH), go IDLE.
- mem_ready outside MRD/MWR is ignored.
- mem_read and mem_write are never both 1.
- Latencies:
  - Write accepted or read hit: request seen in IDLE at cycle 0 → cache_ready in cycle 1.
  - Read miss: mem_read high from cycle 1 → cache_ready 1 cycle after mem_ready.
- Ordering: a read never returns stale memory data for a buffered address, since a match is always served from the buffer.
- Occupancy: wbuf_count updates the cycle after enqueue/dequeue. A coalesce leaves the count unchanged.
- Wrap-around: tail and head wrap independently; full when count==DEPTH.

Test Plan:
- Reset hold, then release → all outputs 0, wbuf_empty=1, no mem_read/mem_write over 10 idle cycles.
- cache_write addr=0x0000010 data=0xAAAA…A → cache_ready in cycle 1, wbuf_count=1. Then idle → mem_write with mem_addr=0x0000010 and that data. mem_ready after 5 cycles → wbuf_empty=1.
- Fill 4 distinct writes (0x1–0x4) with mem_ready withheld, then a 5th write 0x5 → cache_ready held off. Drain of 0x1 starts. mem_ready → 0x5 is accepted into the wrapped slot, wbuf_count=4.
- Write 0x20 data D1, then write 0x20 data D2 before the drain completes → wbuf_count stays 1. Drained mem_wdata=D2.
- Buffered 0x30=D3, cache_read 0x30 → cache_rdata=D3 with cache_ready in cycle 1, no mem_read. cache_read 0x31 → mem_read addr 0x31. mem_rdata=0xBEEF… with mem_ready → same value on cache_rdata one cycle later.
- proc_reset_n low during MWR with 3 entries → mem_write=0 next cycle, wbuf_count=0. No further memory traffic after mem_ready arrives late.
